// File: rtl/multiword_spi_slave.sv
// Oversampled SPI slave streaming WIDTH-bit words in both directions while CS stays asserted.
// Define MULTIWORD_SPI_SLAVE_WORDCOUNT_EN to add the word_count output.
module multiword_spi_slave #(
  parameter int WIDTH     = 32,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             system_clk,
  input  logic             rst,
  input  logic             pin_ncs,
  input  logic             pin_clk,
  input  logic             pin_mosi,
  output logic             pin_miso,
  output logic             pin_miso_en,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             cs_start,
  output logic             cs_stop,
  output logic             underrun,
  output logic             aborted
`ifdef MULTIWORD_SPI_SLAVE_WORDCOUNT_EN
  ,
  output logic [15:0]      word_count
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2:0]       ncs_sync_q, ncs_sync_d, k_sync_q, k_sync_d, mosi_sync_q, mosi_sync_d;
  logic [1:0]       settle_q, settle_d;
  logic             cs_act_q, cs_act_d, skip_q, skip_d, pend_q, pend_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic             tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
  logic             cs_start_q, cs_start_d, cs_stop_q, cs_stop_d;
  logic             underrun_q, underrun_d, aborted_q, aborted_d;

  logic             k_rise, k_fall, sample_evt, shift_evt, start_evt, stop_evt, do_load;
  logic [WIDTH-1:0] rx_shifted, tx_shifted;

  assign k_rise     = k_sync_q[1] & ~k_sync_q[2];
  assign k_fall     = ~k_sync_q[1] & k_sync_q[2];
  assign sample_evt = CPHA ? k_fall : k_rise;
  assign shift_evt  = CPHA ? k_rise : k_fall;

  // The synchroniser is ignored until it has refilled from the pins after reset, so a CS
  // still held low through a reset never looks like a fresh assertion.
  assign start_evt  = (settle_q == 2'd3) & ncs_sync_q[2] & ~ncs_sync_q[1] & ~cs_act_q;
  assign stop_evt   = cs_act_q & ncs_sync_q[1];

  assign rx_shifted = LSB_FIRST ? {mosi_sync_q[2], rx_sh_q[WIDTH-1:1]}
                                : {rx_sh_q[WIDTH-2:0], mosi_sync_q[2]};
  assign tx_shifted = LSB_FIRST ? {1'b0, tx_q[WIDTH-1:1]} : {tx_q[WIDTH-2:0], 1'b0};

  always_comb begin
    ncs_sync_d  = {ncs_sync_q[1:0], pin_ncs};
    k_sync_d    = {k_sync_q[1:0], pin_clk ^ CPOL};
    mosi_sync_d = {mosi_sync_q[1:0], pin_mosi};
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    cs_act_d    = cs_act_q;
    skip_d      = skip_q;
    pend_d      = pend_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    tx_ready_d  = 1'b0;
    rx_valid_d  = 1'b0;
    cs_start_d  = 1'b0;
    cs_stop_d   = 1'b0;
    underrun_d  = 1'b0;
    aborted_d   = 1'b0;
    do_load     = 1'b0;

    if (start_evt) begin
      cs_act_d   = 1'b1;
      cs_start_d = 1'b1;
      bit_cnt_d  = '0;
      pend_d     = 1'b0;
      skip_d     = CPHA;
      do_load    = 1'b1;
    end else if (cs_act_q) begin
      if (sample_evt) begin
        rx_sh_d = rx_shifted;
        if (bit_cnt_q == CW'(WIDTH - 1)) begin
          rx_data_d  = rx_shifted;
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
          pend_d     = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      if (shift_evt) begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (pend_q) begin
          pend_d  = 1'b0;
          do_load = 1'b1;
        end else begin
          tx_d = tx_shifted;
        end
      end
      // A final sample landing with the stop leaves bit_cnt_d at 0, so it is not an abort.
      if (stop_evt) begin
        cs_act_d  = 1'b0;
        cs_stop_d = 1'b1;
        aborted_d = (bit_cnt_d != '0);
        bit_cnt_d = '0;
        pend_d    = 1'b0;
        skip_d    = 1'b0;
      end
    end

    if (do_load) begin
      if (tx_valid) begin
        tx_d       = tx_data;
        tx_ready_d = 1'b1;
      end else begin
        tx_d       = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      ncs_sync_q  <= 3'b111;
      k_sync_q    <= '0;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      cs_act_q    <= 1'b0;
      skip_q      <= 1'b0;
      pend_q      <= 1'b0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      cs_start_q  <= 1'b0;
      cs_stop_q   <= 1'b0;
      underrun_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      ncs_sync_q  <= ncs_sync_d;
      k_sync_q    <= k_sync_d;
      mosi_sync_q <= mosi_sync_d;
      settle_q    <= settle_d;
      cs_act_q    <= cs_act_d;
      skip_q      <= skip_d;
      pend_q      <= pend_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      cs_start_q  <= cs_start_d;
      cs_stop_q   <= cs_stop_d;
      underrun_q  <= underrun_d;
      aborted_q   <= aborted_d;
    end
  end

  assign pin_miso    = LSB_FIRST ? tx_q[0] : tx_q[WIDTH-1];
  assign pin_miso_en = cs_act_q & ~pin_ncs;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign cs_start    = cs_start_q;
  assign cs_stop     = cs_stop_q;
  assign underrun    = underrun_q;
  assign aborted     = aborted_q;

`ifdef MULTIWORD_SPI_SLAVE_WORDCOUNT_EN
  logic [15:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q;
    if (start_evt) begin
      word_count_d = '0;
    end else if (rx_valid_d && (word_count_q != 16'hFFFF)) begin
      word_count_d = word_count_q + 16'd1;
    end
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;
`endif

endmodule
